scroll_update_scheduler: RTL

//  Sequences updates to the scrolling numeric display: arbitrates two number

---
 rtl/scroll_update_scheduler.sv | 117 +++++++++++
 1 files changed

// File: rtl/scroll_update_scheduler.sv
// Purpose: arbitrate two number sources round-robin, then run latch -> settle -> show for the display.
// Latency: transfer to IDLE takes LATCH_CYCLES + SHOW_CYCLES cycles, plus any cycles with hold high in SHOW.
// Backpressure: both reqN_ready are low outside IDLE; hold freezes the SHOW countdown indefinitely.
module scroll_update_scheduler #(
    parameter int DATA_W       = 40,
    parameter int C            = 35,
    parameter int LATCH_CYCLES = 5,
    parameter int SHOW_CYCLES  = 700_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              hold,
    output logic [DATA_W-1:0] disp_number,
    output logic              disp_load,
    output logic              latch_done,
    output logic              display_done,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, SETTLE, SHOW} state_t;

    localparam logic [C-1:0] LATCH_LAST = C'(LATCH_CYCLES - 1);
    localparam logic [C-1:0] SHOW_LAST  = C'(SHOW_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [C-1:0] cnt;
    logic [C-1:0] cnt_nxt;
    logic        last_grant;
    logic        grant;
    logic        transfer;

    // Round-robin grant: a lone requester wins; on a tie the source that did not win last time wins.
    always_comb begin
        grant      = req1_valid && (!req0_valid || !last_grant);
        req0_ready = (state == IDLE) && !grant;
        req1_ready = (state == IDLE) && grant;
        transfer   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    // Status pulses decoded straight from state so they drop at once on reset.
    assign latch_done   = (state == SETTLE) && (cnt == LATCH_LAST);
    assign display_done = (state == SHOW) && (cnt == SHOW_LAST) && !hold;
    assign busy         = (state != IDLE);

    // State and cycle counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter: SETTLE counts every cycle, SHOW only while hold is low.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (transfer) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == LATCH_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + C'(1);
                end
            end
            SHOW: begin
                if (!hold) begin
                    if (cnt == SHOW_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + C'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Capture the granted number only on a transfer; it persists through IDLE for the display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_number <= '0;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            disp_load   <= 1'b0;
        end else begin
            disp_load <= transfer;
            if (transfer) begin
                disp_number <= grant ? req1_data : req0_data;
                grant_id    <= grant;
                last_grant  <= grant;
            end
        end
    end

endmodule
